arcade_input_ctrl: RTL and testbench
====================================

// Module: arcade_input_ctrl
// PURPOSE
//  Input front end for the Phoenix/Pleiads core. Decodes toggle-style PS/2 key events and merges
//  both MiSTer joysticks into the core's button set. Coin is shaped into a fixed-width pulse with
//  re-trigger lockout. Sits between hps_io (ps2_key, joystick_0/1) and the phoenix core's btn_* inputs.
// PARAMETERS
//  COIN_PULSE  110000  clk cycles btn_coin is held high per coin (10 ms @ 11 MHz); must be >=1
//  COIN_GAP    110000  clk cycles of forced-low lockout after coin released; must be >=1
//  CW          17      coin counter width; must hold max(COIN_PULSE,COIN_GAP)
// PORTS
//  clk               in   1   system clock (clk_sys)
//  reset_n           in   1   asynchronous, active-low reset
//  ps2_key           in   11  [10]=event toggle, [9]=pressed, [8]=extended (E0), [7:0]=scan code
//  joystick_0        in   16  player 1 pad: [0]R [1]L [4]fire [5]start1 [6]start2 [7]coin [8]barrier
//  joystick_1        in   16  player 2 pad, same bit map
//  kbd_clear         in   1   synchronous: release every latched key state
//  btn_coin          out  1   shaped coin pulse
//  btn_player_start  out  2   [0]=start 1P, [1]=start 2P
//  btn_left          out  1
//  btn_right         out  1
//  btn_barrier       out  1
//  btn_fire          out  1
// BEHAVIOUR
//  - Reset (reset_n=0, async): all key states 0, all outputs 0, coin FSM IDLE, counter 0, prime=0.
//  - Event detect: toggle_q <= ps2_key[10] each clk. First clk after reset release only loads
//    toggle_q and sets prime=1; no decode. Afterwards ps2_key[10]!=toggle_q is one event.
//  - Decode on event (code={ps2_key[8],ps2_key[7:0]}, X=either extended state), state<=ps2_key[9]:
//    X6B left1; X74 right1; 029 fire1; X14 barrier1; 005/016 start1; 006/01E start2;
//    02E coin1; 036 coin2; 023 left2; 034 right2; 01C fire2; 01B barrier2. Other codes: no change.
//    Two codes sharing a key state (005/016) share one register: last event wins.
//  - kbd_clear=1: all key states <=0 that cycle; overrides a simultaneous event.
//  - Joysticks registered once (joy_q = joystick_0|joystick_1), no debounce.
//  - Outputs registered: left=left1|left2|joy_q[1]; right=right1|right2|joy_q[0];
//    fire=fire1|fire2|joy_q[4]; barrier=barrier1|barrier2|joy_q[8];
//    start[0]=start1|joy_q[5]; start[1]=start2|joy_q[6].
//  - Latency: ps2_key or joystick change -> output = exactly 2 clk.
//  - coin_raw = coin1|coin2|joy_q[7]. Coin FSM, btn_coin registered from state:
//    IDLE : btn_coin=0; coin_raw=1 -> PULSE, cnt<=0.
//    PULSE: btn_coin=1; cnt++; at cnt==COIN_PULSE-1 -> HOLD. Width exactly COIN_PULSE clk,
//           independent of coin_raw (release mid-pulse does not shorten it).
//    HOLD : btn_coin=0; waits for coin_raw=0 -> GAP, cnt<=0 (held key = one coin only).
//    GAP  : btn_coin=0; cnt++; coin_raw=1 restarts cnt<=0; cnt==COIN_GAP-1 -> IDLE.
//  - Counter never wraps: saturating compare ends each count state; CW overflow is a param error.
//  - kbd_clear does not reset the coin FSM; it only drops key states (so FSM proceeds to GAP).
//  - reset_n asserted mid-pulse: btn_coin drops immediately (async), FSM IDLE.
// TESTING (bench with COIN_PULSE=4, COIN_GAP=3)
//  1. Release reset with ps2_key[10]=1 held -> no output change for 10 clk (prime swallows toggle).
//  2. Toggle ps2_key={t,1,1,8'h6B} -> btn_left=1 exactly 2 clk later; {t',0,0,8'h6B} -> btn_left=0.
//  3. joystick_1[7]=1 for 20 clk -> btn_coin high exactly 4 clk, once; deassert, reassert after 1 clk
//     (inside GAP) -> restarts gap, next pulse only after 3 clean low clk.
//  4. Press 016 then 005 press, then 016 release -> btn_player_start[0]=0 (shared state, last wins).
//  5. Press 029 and 01C, assert kbd_clear with simultaneous 034 press event -> btn_fire=0, btn_right=0.
//  6. Assert reset_n=0 during PULSE cycle 2 -> btn_coin=0 same cycle; after release coin_raw=1 -> fresh 4-clk pulse.

Source files
------------

// File: rtl/arcade_input_ctrl.sv
// -----------------------------------------------------------------------------
// arcade_input_ctrl
//   Input front end for the Phoenix/Pleiads core. Decodes toggle-style PS/2
//   key events into latched key states, merges both MiSTer joysticks, and
//   shapes the coin request into a fixed-width pulse with a re-trigger lockout.
//
// Parameters
//   COIN_PULSE : clk cycles btn_coin is held high per coin (>= 1)
//   COIN_GAP   : clk cycles of forced-low lockout after coin released (>= 1)
//   CW         : coin counter width, must hold max(COIN_PULSE, COIN_GAP)
//
// Ports
//   clk              in   system clock
//   reset_n          in   asynchronous active-low reset
//   ps2_key[10:0]    in   [10] event toggle, [9] pressed, [8] extended, [7:0] scan code
//   joystick_0[15:0] in   player 1 pad ([0]R [1]L [4]fire [5]start1 [6]start2 [7]coin [8]barrier)
//   joystick_1[15:0] in   player 2 pad, same bit map
//   kbd_clear        in   synchronous release of every latched key state
//   btn_coin         out  shaped coin pulse
//   btn_player_start out  [0] start 1P, [1] start 2P
//   btn_left/right/barrier/fire  out  merged player controls
//   All outputs are registered; input-to-output latency is two clocks.
// -----------------------------------------------------------------------------
module arcade_input_ctrl #(
    parameter int unsigned COIN_PULSE = 110000,
    parameter int unsigned COIN_GAP   = 110000,
    parameter int unsigned CW         = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        kbd_clear,
    output logic        btn_coin,
    output logic [1:0]  btn_player_start,
    output logic        btn_left,
    output logic        btn_right,
    output logic        btn_barrier,
    output logic        btn_fire
);

    // Bit positions of the latched key states
    localparam int K_LEFT1    = 0;
    localparam int K_RIGHT1   = 1;
    localparam int K_FIRE1    = 2;
    localparam int K_BARRIER1 = 3;
    localparam int K_START1   = 4;
    localparam int K_START2   = 5;
    localparam int K_COIN1    = 6;
    localparam int K_COIN2    = 7;
    localparam int K_LEFT2    = 8;
    localparam int K_RIGHT2   = 9;
    localparam int K_FIRE2    = 10;
    localparam int K_BARRIER2 = 11;

    localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE - 32'd1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP - 32'd1);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } coin_state_t;

    logic              toggle_r;
    logic              prime_r;
    logic [11:0]       key_r;
    logic [11:0]       key_next_s;
    logic [15:0]       joy_r;
    logic              event_s;
    logic [8:0]        code_s;
    logic              coin_raw_s;
    coin_state_t       state_r;
    coin_state_t       state_next_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_next_s;
    logic              unused_joy_s;

    // Pad bits with no function in this core
    assign unused_joy_s = ^{joy_r[15:9], joy_r[3:2]};

    // prime_r masks the first clock after reset so a toggle bit already high
    // at release is not mistaken for a key event.
    assign event_s = prime_r && (ps2_key[10] != toggle_r);
    assign code_s  = {ps2_key[8], ps2_key[7:0]};

    // Next key-state vector: clear wins over a decoded event
    always_comb begin
        key_next_s = key_r;
        if (kbd_clear) begin
            key_next_s = 12'h000;
        end else if (event_s) begin
            case (code_s)
                9'h06B, 9'h16B: key_next_s[K_LEFT1]    = ps2_key[9];
                9'h074, 9'h174: key_next_s[K_RIGHT1]   = ps2_key[9];
                9'h029:         key_next_s[K_FIRE1]    = ps2_key[9];
                9'h014, 9'h114: key_next_s[K_BARRIER1] = ps2_key[9];
                9'h005, 9'h016: key_next_s[K_START1]   = ps2_key[9];
                9'h006, 9'h01E: key_next_s[K_START2]   = ps2_key[9];
                9'h02E:         key_next_s[K_COIN1]    = ps2_key[9];
                9'h036:         key_next_s[K_COIN2]    = ps2_key[9];
                9'h023:         key_next_s[K_LEFT2]    = ps2_key[9];
                9'h034:         key_next_s[K_RIGHT2]   = ps2_key[9];
                9'h01C:         key_next_s[K_FIRE2]    = ps2_key[9];
                9'h01B:         key_next_s[K_BARRIER2] = ps2_key[9];
                default:        key_next_s = key_r;
            endcase
        end else begin
            key_next_s = key_r;
        end
    end

    // Event detector, key-state latches and joystick capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_r <= 1'b0;
            prime_r  <= 1'b0;
            key_r    <= 12'h000;
            joy_r    <= 16'h0000;
        end else begin
            toggle_r <= ps2_key[10];
            prime_r  <= 1'b1;
            key_r    <= key_next_s;
            joy_r    <= joystick_0 | joystick_1;
        end
    end

    // Registered player controls merged from keyboard and pads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_left         <= 1'b0;
            btn_right        <= 1'b0;
            btn_fire         <= 1'b0;
            btn_barrier      <= 1'b0;
            btn_player_start <= 2'b00;
        end else begin
            btn_left            <= key_r[K_LEFT1] | key_r[K_LEFT2] | joy_r[1];
            btn_right           <= key_r[K_RIGHT1] | key_r[K_RIGHT2] | joy_r[0];
            btn_fire            <= key_r[K_FIRE1] | key_r[K_FIRE2] | joy_r[4];
            btn_barrier         <= key_r[K_BARRIER1] | key_r[K_BARRIER2] | joy_r[8];
            btn_player_start[0] <= key_r[K_START1] | joy_r[5];
            btn_player_start[1] <= key_r[K_START2] | joy_r[6];
        end
    end

    assign coin_raw_s = key_r[K_COIN1] | key_r[K_COIN2] | joy_r[7];

    // Coin shaper next state: fixed pulse, wait for release, then clean-low gap.
    // Count states end on >= so an out-of-range count can never run away.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (coin_raw_s) begin
                    state_next_s = ST_PULSE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_r >= PULSE_LAST) begin
                    state_next_s = ST_HOLD;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!coin_raw_s) begin
                    state_next_s = ST_GAP;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (coin_raw_s) begin
                    cnt_next_s = CNT_ZERO;
                end else if (cnt_r >= GAP_LAST) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Coin shaper state, counter and registered pulse output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            btn_coin <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            btn_coin <= (state_next_s == ST_PULSE);
        end
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl (COIN_PULSE=4, COIN_GAP=3).
// Stimulus updates a behavioural model and queues the expected outputs for the
// clock at which they must appear; an independent monitor pops and compares.
module tb_arcade_input_ctrl;

    localparam int P = 4;
    localparam int G = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        kbd_clear;
    logic        btn_coin;
    logic [1:0]  btn_player_start;
    logic        btn_left;
    logic        btn_right;
    logic        btn_barrier;
    logic        btn_fire;

    always #5 clk = ~clk;

    arcade_input_ctrl #(.COIN_PULSE(P), .COIN_GAP(G), .CW(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ps2_key          (ps2_key),
        .joystick_0       (joystick_0),
        .joystick_1       (joystick_1),
        .kbd_clear        (kbd_clear),
        .btn_coin         (btn_coin),
        .btn_player_start (btn_player_start),
        .btn_left         (btn_left),
        .btn_right        (btn_right),
        .btn_barrier      (btn_barrier),
        .btn_fire         (btn_fire)
    );

    typedef struct packed {
        int         cyc;
        logic [6:0] outs;   // {coin, start[1:0], left, right, barrier, fire}
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   pc          = 0;
    bit   mon_en      = 1'b0;

    // Behavioural model state
    bit    keys[string];
    bit    m_primed;
    bit    m_last_t;
    int    m_pulse_left;
    bit    m_lock;
    bit    m_released;
    int    m_low_run;

    logic [7:0] codes [16] = '{8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h16, 8'h06, 8'h1E,
                               8'h2E, 8'h36, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h5A, 8'h12};

    always @(posedge clk) pc <= pc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at clk %0d: got %0h expected %0h", name, pc, act, exp_v);
        end
    endtask

    function automatic logic [6:0] dut_outs();
        return {btn_coin, btn_player_start, btn_left, btn_right, btn_barrier, btn_fire};
    endfunction

    // Which game function a key maps to; "" for keys the core ignores
    function automatic string role_of(input bit ext, input logic [7:0] sc);
        case (sc)
            8'h6B: return "left1";
            8'h74: return "right1";
            8'h14: return "barrier1";
            default: ;
        endcase
        if (ext) return "";
        case (sc)
            8'h29: return "fire1";
            8'h05, 8'h16: return "start1";
            8'h06, 8'h1E: return "start2";
            8'h2E: return "coin1";
            8'h36: return "coin2";
            8'h23: return "left2";
            8'h34: return "right2";
            8'h1C: return "fire2";
            8'h1B: return "barrier2";
            default: return "";
        endcase
    endfunction

    task automatic model_reset();
        string names[12] = '{"left1", "right1", "fire1", "barrier1", "start1", "start2",
                             "coin1", "coin2", "left2", "right2", "fire2", "barrier2"};
        foreach (names[i]) keys[names[i]] = 1'b0;
        m_primed     = 1'b0;
        m_last_t     = 1'b0;
        m_pulse_left = 0;
        m_lock       = 1'b0;
        m_released   = 1'b0;
        m_low_run    = 0;
    endtask

    // One clock of inputs -> outputs expected two clocks later
    task automatic model_step(output exp_t e);
        logic [15:0] j;
        string r;
        bit c, coin;
        j = joystick_0 | joystick_1;
        if (kbd_clear) begin
            foreach (keys[k]) keys[k] = 1'b0;
        end else if (m_primed && (ps2_key[10] != m_last_t)) begin
            r = role_of(ps2_key[8], ps2_key[7:0]);
            if (r != "") keys[r] = ps2_key[9];
        end
        m_primed = 1'b1;
        m_last_t = ps2_key[10];

        c = keys["coin1"] | keys["coin2"] | j[7];
        if (m_pulse_left > 0) begin
            m_pulse_left--;
            coin = (m_pulse_left > 0);
            if (m_pulse_left == 0) begin
                m_lock     = 1'b1;
                m_released = 1'b0;
            end
        end else if (m_lock) begin
            coin = 1'b0;
            if (!m_released) begin
                if (!c) begin
                    m_released = 1'b1;
                    m_low_run  = 0;
                end
            end else if (c) begin
                m_low_run = 0;
            end else begin
                m_low_run++;
                if (m_low_run >= G) m_lock = 1'b0;
            end
        end else begin
            coin = c;
            if (c) m_pulse_left = P;
        end

        e.cyc  = pc + 2;
        e.outs = {coin,
                  keys["start2"] | j[6], keys["start1"] | j[5],
                  keys["left1"] | keys["left2"] | j[1],
                  keys["right1"] | keys["right2"] | j[0],
                  keys["barrier1"] | keys["barrier2"] | j[8],
                  keys["fire1"] | keys["fire2"] | j[4]};
    endtask

    // Monitor: compare DUT outputs against the queued expectation for this clock
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < pc) begin
                e = sb_q.pop_front();
                check("missed_expectation", 32'(e.cyc), 32'(pc));
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == pc) begin
                e = sb_q.pop_front();
                check("outputs", 32'(dut_outs()), 32'(e.outs));
            end
        end
    end

    // Called at a falling edge with inputs already set
    task automatic cycle();
        exp_t e;
        model_step(e);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic key_event(input bit ext, input bit pressed, input logic [7:0] sc, input int idle);
        ps2_key = {~ps2_key[10], pressed, ext, sc};
        cycle();
        repeat (idle) cycle();
    endtask

    // Assert reset between edges, check the async clear, release on a falling edge
    task automatic apply_reset(input int hold);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("reset_outputs", 32'(dut_outs()), 32'd0);
        repeat (hold) @(negedge clk);
        sb_q.delete();
        model_reset();
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        ps2_key    = 11'h000;
        joystick_0 = 16'h0000;
        joystick_1 = 16'h0000;
        kbd_clear  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", 32'(dut_outs()), 32'd0);

        // 1: toggle already high at release must be swallowed
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h6B};
        apply_reset(2);
        repeat (10) cycle();

        // 2: extended left press / plain left release, exact 2-clk latency
        key_event(1'b1, 1'b1, 8'h6B, 4);
        key_event(1'b0, 1'b0, 8'h6B, 4);

        // 3: held coin gives one pulse; re-trigger inside the gap restarts it
        joystick_1[7] = 1'b1; repeat (20) cycle();
        joystick_1[7] = 1'b0; cycle();
        joystick_1[7] = 1'b1; cycle();
        joystick_1[7] = 1'b0; repeat (2) cycle();
        joystick_1[7] = 1'b1; cycle();
        joystick_1[7] = 1'b0; repeat (3) cycle();
        joystick_1[7] = 1'b1; repeat (6) cycle();
        joystick_1[7] = 1'b0; repeat (8) cycle();

        // 4: two codes sharing start1, last event wins
        key_event(1'b0, 1'b1, 8'h16, 2);
        key_event(1'b0, 1'b1, 8'h05, 2);
        key_event(1'b0, 1'b0, 8'h16, 3);
        check("start_shared", 32'(btn_player_start[0]), 32'd0);

        // 5: kbd_clear overrides a simultaneous right2 press
        key_event(1'b0, 1'b1, 8'h29, 1);
        key_event(1'b0, 1'b1, 8'h1C, 3);
        kbd_clear = 1'b1;
        key_event(1'b0, 1'b1, 8'h34, 0);
        kbd_clear = 1'b0;
        repeat (3) cycle();
        check("clear_fire", 32'(btn_fire), 32'd0);
        check("clear_right", 32'(btn_right), 32'd0);

        // 6: reset in the second pulse clock, then a fresh pulse
        repeat (6) cycle();
        joystick_0[7] = 1'b1;
        repeat (3) cycle();
        check("coin_pre_reset", 32'(btn_coin), 32'd1);
        apply_reset(2);
        repeat (10) cycle();
        joystick_0[7] = 1'b0;
        repeat (6) cycle();

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0)
                ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom), codes[$urandom_range(0, 15)]};
            if ($urandom_range(0, 9) == 0)
                joystick_0 = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 9) == 0)
                joystick_1 = 16'($urandom) & 16'($urandom) & 16'($urandom);
            kbd_clear = ($urandom_range(0, 40) == 0);
            cycle();
        end

        joystick_0 = 16'h0000;
        joystick_1 = 16'h0000;
        kbd_clear  = 1'b0;
        repeat (4) cycle();
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
